// File: rtl/qspi_page_writer.sv
// Gathers a byte stream into 256-byte flash pages and programs each one with WREN/PP/RDSR.
// Defining QSPI_PAGE_WRITER_ERASE_EN adds WREN/SE/RDSR at each sector boundary.
module qspi_page_writer #(
    parameter logic [23:0] START_ADDR  = 24'h000000,
    parameter int          SECTOR_BITS = 16,
    parameter int          POLL_LIMIT  = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 trigger,
    output logic [7:0]           cmd,
    output logic [(3+256)*8-1:0] data_send,
    input  logic [7:0]           readout,
    input  logic                 busy,
    input  logic                 error,
    output logic                 done,
    output logic                 fail,
    output logic [15:0]          pages_written
);
    localparam logic [7:0]  CMD_WREN = 8'h06;
    localparam logic [7:0]  CMD_SE   = 8'hD8;
    localparam logic [7:0]  CMD_PP   = 8'h02;
    localparam logic [7:0]  CMD_RDSR = 8'h05;
    localparam logic [31:0] POLL_MAX = 32'(POLL_LIMIT);

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_WREN, S_ERASE, S_PROG,
        S_POLL, S_WAIT, S_NEXT, S_DONE, S_FAIL
    } state_t;

    state_t          state_q;
    logic [23:0]     addr_q;
    logic [2047:0]   page_q;
    logic [7:0]      idx_q;
    logic            last_q;
    logic            skip_q;
    logic [31:0]     polls_q;
    logic            in_ready_q;
    logic            trigger_q;
    logic [7:0]      cmd_q;
    logic [2071:0]   data_q;
    logic            done_q;
    logic            fail_q;
    logic [15:0]     pages_q;
`ifdef QSPI_PAGE_WRITER_ERASE_EN
    logic            erase_q;
`endif

    logic [7:0] op;
    logic       accept;
    logic       unused_rd;

    assign accept    = in_valid && in_ready_q;
    assign unused_rd = ^readout[7:1];

    always_comb begin
        case (state_q)
            S_WREN:  op = CMD_WREN;
            S_ERASE: op = CMD_SE;
            S_PROG:  op = CMD_PP;
            default: op = CMD_RDSR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= START_ADDR & 24'hFFFF00;
            page_q     <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            skip_q     <= 1'b0;
            polls_q    <= '0;
            in_ready_q <= 1'b0;
            trigger_q  <= 1'b0;
            cmd_q      <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            pages_q    <= '0;
`ifdef QSPI_PAGE_WRITER_ERASE_EN
            erase_q    <= 1'b0;
`endif
        end else begin
            trigger_q <= 1'b0;
            case (state_q)
                S_IDLE: if (!busy) begin
                    state_q <= S_FILL;
                    idx_q   <= '0;
                    page_q  <= '1;
                    last_q  <= 1'b0;
                end
                S_FILL: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        // Page pre-filled with 0xFF, so a short page is already padded.
                        page_q[{~idx_q, 3'b111} -: 8] <= in_data;
                        idx_q <= idx_q + 8'd1;
                        if (in_last || idx_q == 8'hFF) begin
                            in_ready_q <= 1'b0;
                            last_q     <= in_last;
                            state_q    <= S_WREN;
`ifdef QSPI_PAGE_WRITER_ERASE_EN
                            erase_q    <= (addr_q[SECTOR_BITS-1:0] == '0);
`endif
                        end
                    end
                end
                S_WREN, S_ERASE, S_PROG, S_POLL: begin
                    cmd_q     <= op;
                    data_q    <= {addr_q, page_q};
                    trigger_q <= 1'b1;
                    skip_q    <= 1'b1;
                    state_q   <= S_WAIT;
                    if (state_q == S_POLL) polls_q <= polls_q + 32'd1;
                end
                S_WAIT: if (skip_q) begin
                    skip_q <= 1'b0;
                end else if (!busy) begin
                    if (error) begin
                        fail_q  <= 1'b1;
                        state_q <= S_FAIL;
                    end else begin
                        case (cmd_q)
`ifdef QSPI_PAGE_WRITER_ERASE_EN
                            CMD_WREN: state_q <= erase_q ? S_ERASE : S_PROG;
`else
                            CMD_WREN: state_q <= S_PROG;
`endif
                            CMD_SE, CMD_PP: begin
                                polls_q <= '0;
                                state_q <= S_POLL;
                            end
                            default: if (readout[0]) begin
                                if (polls_q > POLL_MAX) begin
                                    fail_q  <= 1'b1;
                                    state_q <= S_FAIL;
                                end else begin
                                    state_q <= S_POLL;
                                end
`ifdef QSPI_PAGE_WRITER_ERASE_EN
                            end else if (erase_q) begin
                                erase_q <= 1'b0;
                                state_q <= S_WREN;
`endif
                            end else begin
                                state_q <= S_NEXT;
                            end
                        endcase
                    end
                end
                S_NEXT: begin
                    addr_q  <= addr_q + 24'd256;
                    pages_q <= pages_q + 16'd1;
                    if (last_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_FILL;
                        idx_q   <= '0;
                        page_q  <= '1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign trigger       = trigger_q;
    assign cmd           = cmd_q;
    assign data_send     = data_q;
    assign done          = done_q;
    assign fail          = fail_q;
    assign pages_written = pages_q;
endmodule

// File: tb/tb_qspi_page_writer.sv
// Randomized bench for qspi_page_writer: controller model records commands,
// and each run is compared against a page-level expected command list.
module tb_qspi_page_writer;
    localparam logic [23:0] BASE    = 24'hFFFF00;
    localparam logic [7:0]  OP_WREN = 8'h06;
    localparam logic [7:0]  OP_SE   = 8'hD8;
    localparam logic [7:0]  OP_PP   = 8'h02;
    localparam logic [7:0]  OP_RDSR = 8'h05;
`ifdef QSPI_PAGE_WRITER_ERASE_EN
    localparam bit ERASE = 1'b1;
`else
    localparam bit ERASE = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic [7:0]    in_data  = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic          in_ready;
    logic          trigger;
    logic [7:0]    cmd;
    logic [2071:0] data_send;
    logic [7:0]    readout  = 8'h00;
    logic          busy     = 1'b0;
    logic          error    = 1'b0;
    logic          done;
    logic          fail;
    logic [15:0]   pages_written;

    int total = 0;
    int bad   = 0;

    logic [2079:0] trace[$];
    logic [7:0]    bytes[$];
    int            wip_n    = 0;
    int            err_at   = -1;
    int            wip_left = 0;
    int            pp_cnt   = 0;
    int            lat      = 0;
    logic [7:0]    nxt_rd   = 8'h00;
    logic          nxt_err  = 1'b0;

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        bit          has_addr;
        int          page;
    } exp_t;

    qspi_page_writer #(
        .START_ADDR (24'hFFFF5A),
        .SECTOR_BITS(16),
        .POLL_LIMIT (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .trigger      (trigger),
        .cmd          (cmd),
        .data_send    (data_send),
        .readout      (readout),
        .busy         (busy),
        .error        (error),
        .done         (done),
        .fail         (fail),
        .pages_written(pages_written)
    );

    always #5 clk = ~clk;

    // Controller + flash status model
    always @(negedge clk) begin
        if (reset) begin
            busy  = 1'b0;
            error = 1'b0;
            lat   = 0;
        end else if (trigger) begin
            trace.push_back({cmd, data_send});
            nxt_err = 1'b0;
            nxt_rd  = {7'($urandom), 1'b0};
            if (cmd == OP_RDSR && wip_left > 0) begin
                nxt_rd[0] = 1'b1;
                wip_left--;
            end
            if (cmd == OP_SE || cmd == OP_PP) wip_left = wip_n;
            if (cmd == OP_PP) begin
                nxt_err = (pp_cnt == err_at);
                pp_cnt++;
            end
            lat = $urandom_range(0, 3);
            if (lat == 0) begin
                busy    = 1'b0;
                readout = nxt_rd;
                error   = nxt_err;
            end else begin
                busy = 1'b1;
            end
        end else if (busy) begin
            lat--;
            if (lat == 0) begin
                busy    = 1'b0;
                readout = nxt_rd;
                error   = nxt_err;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill_bytes(input int len, input bit seq);
        bytes.delete();
        for (int i = 0; i < len; i++) bytes.push_back(seq ? 8'(i) : 8'($urandom));
    endtask

    task automatic send(input int len, input int stop);
        int i = 0;
        int g = 0;
        while (i < stop && g < 4000) begin
            @(negedge clk);
            g++;
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = bytes[i];
            in_last  = (i == len - 1);
            if (in_valid && in_ready) i++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("stream", 64'(i), 64'(stop));
    endtask

    task automatic wait_end();
        int g = 0;
        while (!(done || fail) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic run(input int len, input int wip, input bit seq);
        exp_t          ex[$];
        logic [23:0]   a;
        logic [2079:0] ent;
        logic [7:0]    eb;
        int            np, t0, n, nb;
        apply_reset();
        fill_bytes(len, seq);
        wip_n  = wip;
        err_at = -1;
        t0     = trace.size();
        send(len, len);
        wait_end();
        np = (len + 255) / 256;
        a  = BASE;
        for (int p = 0; p < np; p++) begin
            if (ERASE && a[15:0] == 16'h0000) begin
                ex.push_back('{OP_WREN, a, 1'b0, -1});
                ex.push_back('{OP_SE, a, 1'b1, -1});
                for (int k = 0; k <= wip; k++) ex.push_back('{OP_RDSR, a, 1'b0, -1});
            end
            ex.push_back('{OP_WREN, a, 1'b0, -1});
            ex.push_back('{OP_PP, a, 1'b1, p});
            for (int k = 0; k <= wip; k++) ex.push_back('{OP_RDSR, a, 1'b0, -1});
            a = a + 24'd256;
        end
        chk("done", 64'(done), 64'd1);
        chk("fail", 64'(fail), 64'd0);
        chk("pages", 64'(pages_written), 64'(np));
        chk("ready_end", 64'(in_ready), 64'd0);
        n = trace.size() - t0;
        chk("ncmd", 64'(n), 64'(ex.size()));
        for (int i = 0; i < n && i < ex.size(); i++) begin
            ent = trace[t0 + i];
            chk("cmd", 64'(ent[2079:2072]), 64'(ex[i].op));
            if (ex[i].has_addr) chk("addr", 64'(ent[2071:2048]), 64'(ex[i].addr));
            if (ex[i].page >= 0) begin
                nb = 0;
                for (int b = 0; b < 256; b++) begin
                    eb = (ex[i].page * 256 + b < len) ? bytes[ex[i].page * 256 + b] : 8'hFF;
                    if (ent[2047 - 8 * b -: 8] !== eb) nb++;
                end
                chk("pp_data", 64'(nb), 64'd0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_trigger"}, 64'(trigger), 64'd0);
        chk({pfx, "_ready"}, 64'(in_ready), 64'd0);
        chk({pfx, "_cmd"}, 64'(cmd), 64'd0);
        chk({pfx, "_data"}, 64'(|data_send), 64'd0);
        chk({pfx, "_done"}, 64'(done), 64'd0);
        chk({pfx, "_fail"}, 64'(fail), 64'd0);
        chk({pfx, "_pages"}, 64'(pages_written), 64'd0);
    endtask

    initial begin
        int t0, nr;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        run(256, 0, 1'b1);

        // Reset pulsed while the second page is filling
        apply_reset();
        fill_bytes(300, 1'b0);
        wip_n  = 0;
        err_at = -1;
        send(300, 280);
        chk("mid_pages", 64'(pages_written), 64'd1);
        chk("mid_ready", 64'(in_ready), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        @(negedge clk);
        reset = 1'b0;

        run(512, 3, 1'b0);
        run(300, 1, 1'b0);
        run(1, 2, 1'b0);
        for (int r = 0; r < 3; r++) run($urandom_range(1, 700), $urandom_range(0, 3), 1'b0);

        // Flash never clears WIP: poll limit must trip
        apply_reset();
        fill_bytes(10, 1'b0);
        wip_n  = 1000;
        err_at = -1;
        t0     = trace.size();
        send(10, 10);
        wait_end();
        nr = 0;
        for (int i = t0; i < trace.size(); i++)
            if (trace[i][2079:2072] == OP_RDSR) nr++;
        chk("poll_rdsr", 64'(nr), 64'd11);
        chk("poll_fail", 64'(fail), 64'd1);
        chk("poll_done", 64'(done), 64'd0);
        chk("poll_pages", 64'(pages_written), 64'd0);
        chk("poll_ready", 64'(in_ready), 64'd0);

        // Controller error on the second page program
        apply_reset();
        fill_bytes(300, 1'b0);
        wip_n  = 0;
        err_at = pp_cnt + 1;
        send(300, 300);
        wait_end();
        chk("err_fail", 64'(fail), 64'd1);
        chk("err_done", 64'(done), 64'd0);
        chk("err_pages", 64'(pages_written), 64'd1);
        err_at = -1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
